// File: rtl/multi_pkg.sv
// Shared definitions for the sequential shift-and-add multiplier.
// Holds the FSM state encoding and the default operand width.
package multi_pkg;

    // Default operand width; the product is twice this wide.
    localparam int DEFAULT_WIDTH = 4;

    // Controller states: waiting for operands, iterating, holding a result.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/multi_step.sv
// One iteration of the shift-and-add multiplier, purely combinational.
// If the LSB of p is set, a is added into the upper half of p at WIDTH+1
// bits. The result, carry included, is then shifted right by one.
module multi_step #(
    parameter int WIDTH = 4
) (
    input  logic [2*WIDTH-1:0] p,
    input  logic [WIDTH-1:0]   a,
    output logic [2*WIDTH-1:0] p_next
);

    logic [WIDTH:0] upper;

    // Conditional add into the upper half, then shift right with carry.
    always_comb begin
        upper  = {1'b0, p[2*WIDTH-1:WIDTH]} + (p[0] ? {1'b0, a} : {(WIDTH+1){1'b0}});
        p_next = {upper, p[WIDTH-1:1]};
    end

endmodule

// File: rtl/multi_seq_nbits.sv
// Sequential WIDTH x WIDTH multiplier. It retires one multiplier bit per
// enabled cycle and takes WIDTH cycles per product.
//
// Handshake: the input side transfers on in_valid && in_ready, and
// in_ready is high only in IDLE. The output side transfers on
// out_valid && out_ready. out_valid stays high with io_Product stable
// until that transfer happens.
//
// Optional build macro MULTI_SIGNED_EN adds the sgn input. When sgn=1 the
// operands are two's complement. The datapath multiplies magnitudes, and
// the product is negated on the BUSY->DONE edge if the operand signs differ.
//
// dbg_state exposes the controller state so checkers can bind to it.
module multi_seq_nbits
    import multi_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ena,
`ifdef MULTI_SIGNED_EN
    input  logic               sgn,
`endif
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   io_A,
    input  logic [WIDTH-1:0]   io_B,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] io_Product,
    output state_t             dbg_state
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]     a_q, a_d;
    logic [2*WIDTH-1:0]   p_q, p_d;
    logic [2*WIDTH-1:0]   prod_q, prod_d;
    logic [2*WIDTH-1:0]   step_p;
    logic [2*WIDTH-1:0]   final_p;
    logic [WIDTH-1:0]     mag_a, mag_b;
    logic                 neg_q, neg_d;

    multi_step #(.WIDTH(WIDTH)) u_step (
        .p      (p_q),
        .a      (a_q),
        .p_next (step_p)
    );

`ifdef MULTI_SIGNED_EN
    // Magnitudes of signed operands. -2^(WIDTH-1) maps onto itself, and
    // that bit pattern reads correctly as the unsigned value 2^(WIDTH-1).
    always_comb begin
        mag_a   = (sgn && io_A[WIDTH-1]) ? (~io_A + 1'b1) : io_A;
        mag_b   = (sgn && io_B[WIDTH-1]) ? (~io_B + 1'b1) : io_B;
        neg_d   = sgn & (io_A[WIDTH-1] ^ io_B[WIDTH-1]);
        final_p = neg_q ? (~step_p + 1'b1) : step_p;
    end
`else
    // Unsigned only: operands pass straight through, and there is no sign state.
    always_comb begin
        mag_a   = io_A;
        mag_b   = io_B;
        neg_d   = 1'b0;
        final_p = step_p;
    end
`endif

    // Next-state and datapath-load logic for the controller.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        p_d     = p_q;
        prod_d  = prod_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    a_d     = mag_a;
                    p_d     = {{WIDTH{1'b0}}, mag_b};
                    cnt_d   = CNT_W'(WIDTH);
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                p_d   = step_p;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    p_d     = final_p;
                    prod_d  = final_p;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers. With ena low, all of them hold.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            p_q     <= '0;
            prod_q  <= '0;
        end else if (ena) begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            p_q     <= p_d;
            prod_q  <= prod_d;
        end
    end

`ifdef MULTI_SIGNED_EN
    // Sign of the product, captured when the operands are accepted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            neg_q <= 1'b0;
        end else if (ena && state_q == ST_IDLE && in_valid) begin
            neg_q <= neg_d;
        end
    end
`else
    // No sign state in the unsigned build.
    always_comb begin
        neg_q = 1'b0;
    end
`endif

    // Handshake outputs decode directly from the registered state.
    always_comb begin
        in_ready   = (state_q == ST_IDLE);
        out_valid  = (state_q == ST_DONE);
        io_Product = prod_q;
        dbg_state  = state_q;
    end

endmodule

// File: tb/tb_multi_seq_nbits.sv
// Directed testbench for multi_seq_nbits, covering WIDTH=4 and WIDTH=8 instances.
// With MULTI_SIGNED_EN defined, it also runs the signed vectors.
module tb_multi_seq_nbits;
    import multi_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic ena = 1'b1;
    always #5 clk = ~clk;

    // WIDTH=4 instance signals
    logic       in_valid4 = 1'b0, out_ready4 = 1'b1, sgn4 = 1'b0;
    logic [3:0] io_a4 = '0, io_b4 = '0;
    logic       in_ready4, out_valid4;
    logic [7:0] prod4;
    state_t     st4;

    // WIDTH=8 instance signals
    logic        in_valid8 = 1'b0, out_ready8 = 1'b1, sgn8 = 1'b0;
    logic [7:0]  io_a8 = '0, io_b8 = '0;
    logic        in_ready8, out_valid8;
    logic [15:0] prod8;
    state_t      st8;

    int tests_run = 0;
    int tests_failed = 0;
    int lat;

    multi_seq_nbits #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .ena(ena),
`ifdef MULTI_SIGNED_EN
        .sgn(sgn4),
`endif
        .in_valid(in_valid4), .in_ready(in_ready4),
        .io_A(io_a4), .io_B(io_b4),
        .out_valid(out_valid4), .out_ready(out_ready4),
        .io_Product(prod4), .dbg_state(st4)
    );

    multi_seq_nbits #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .ena(ena),
`ifdef MULTI_SIGNED_EN
        .sgn(sgn8),
`endif
        .in_valid(in_valid8), .in_ready(in_ready8),
        .io_A(io_a8), .io_B(io_b8),
        .out_valid(out_valid8), .out_ready(out_ready8),
        .io_Product(prod8), .dbg_state(st8)
    );

    // ---------------- driver tasks ----------------
    // Advance one clock; sample point is 1ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Present operands for one cycle; returns just after the accept edge.
    task automatic start4(input logic [3:0] a, input logic [3:0] b, input logic s);
        io_a4 = a; io_b4 = b; sgn4 = s; in_valid4 = 1'b1;
        step();
        in_valid4 = 1'b0;
    endtask

    task automatic start8(input logic [7:0] a, input logic [7:0] b);
        io_a8 = a; io_b8 = b; in_valid8 = 1'b1;
        step();
        in_valid8 = 1'b0;
    endtask

    // Count edges until out_valid, bounded.
    task automatic wait_done4(output int n);
        n = 0;
        while (!out_valid4 && n < 40) begin step(); n++; end
    endtask

    task automatic wait_done8(output int n);
        n = 0;
        while (!out_valid8 && n < 40) begin step(); n++; end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        #12;
        // Reset state
        check("rst_in_ready", in_ready4, 1);
        check("rst_out_valid", out_valid4, 0);
        check("rst_product", prod4, 0);
        check("rst_state", st4, ST_IDLE);
        rst = 1'b1;
        step();

        // 1: 15*15 with exact latency, then result held into IDLE
        check("pre_in_ready", in_ready4, 1);
        start4(4'd15, 4'd15, 1'b0);
        check("busy_in_ready", in_ready4, 0);
        wait_done4(lat);
        check("lat_15x15", lat, 4);
        check("prod_15x15", prod4, 225);
        step();
        check("idle_in_ready", in_ready4, 1);
        check("idle_out_valid", out_valid4, 0);
        check("idle_prod_held", prod4, 225);
        start4(4'd0, 4'd9, 1'b0);
        wait_done4(lat);
        check("lat_0x9", lat, 4);
        check("prod_0x9", prod4, 0);
        step();

        // 2: backpressure, with a new operand offered during DONE ignored
        out_ready4 = 1'b0;
        start4(4'd6, 4'd7, 1'b0);
        wait_done4(lat);
        check("lat_6x7", lat, 4);
        io_a4 = 4'd3; io_b4 = 4'd3; in_valid4 = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            check("bp_out_valid", out_valid4, 1);
            check("bp_prod", prod4, 42);
            check("bp_in_ready", in_ready4, 0);
        end
        in_valid4 = 1'b0;
        out_ready4 = 1'b1;
        step();
        check("bp_release", in_ready4, 1);
        start4(4'd3, 4'd3, 1'b0);
        wait_done4(lat);
        check("prod_3x3", prod4, 9);
        step();

        // 3: ena gating stretches latency by exactly the frozen cycles
        start4(4'd13, 4'd11, 1'b0);
        step(); step();
        ena = 1'b0;
        step(); step(); step();
        check("frozen_state", st4, ST_BUSY);
        ena = 1'b1;
        wait_done4(lat);
        check("lat_ena", lat + 5, 7);
        check("prod_13x11", prod4, 143);
        step();

        // 4: asynchronous reset mid-operation
        start4(4'd9, 4'd9, 1'b0);
        step();
        #2 rst = 1'b0;
        #1;
        check("arst_out_valid", out_valid4, 0);
        check("arst_in_ready", in_ready4, 1);
        check("arst_product", prod4, 0);
        #1 rst = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            check("arst_no_result", out_valid4, 0);
        end

        // 5: WIDTH=8 instance
        start8(8'd255, 8'd255);
        wait_done8(lat);
        check("lat8_255x255", lat, 8);
        check("prod8_255x255", prod8, 65025);
        step();
        start8(8'd128, 8'd2);
        wait_done8(lat);
        check("prod8_128x2", prod8, 256);
        step();

`ifdef MULTI_SIGNED_EN
        // 6: signed operands
        start4(4'h8, 4'd7, 1'b1);
        wait_done4(lat);
        check("lat_s_m8x7", lat, 4);
        check("prod_s_m8x7", prod4, 8'hC8);
        step();
        start4(4'h8, 4'h8, 1'b1);
        wait_done4(lat);
        check("prod_s_m8xm8", prod4, 64);
        step();
        start4(4'hF, 4'h2, 1'b0);
        wait_done4(lat);
        check("prod_u_15x2", prod4, 30);
        step();
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
